// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: PC load path, imem request/response and IF/ID handshake.
// The master side is the fetch unit; the slave side is its environment.
interface if_fetch_unit_if #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 32
);
    logic              pc_load;
    logic [WIDTH-1:0]  pc_addr;
    logic [WIDTH-1:0]  nxt_pc;
    logic              redirect_valid;
    logic [WIDTH-1:0]  redirect_target;
    logic              imem_req_valid;
    logic [WIDTH-1:0]  imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [WIDTH-1:0]  id_pc;
    logic [WIDTH-1:0]  id_pc_plus4;
    logic              id_ready;

    modport master (
        input  pc_addr, redirect_valid, redirect_target,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_load, nxt_pc, imem_req_valid, imem_req_addr,
        output id_valid, id_inst, id_pc, id_pc_plus4
    );

    modport slave (
        output pc_addr, redirect_valid, redirect_target,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_load, nxt_pc, imem_req_valid, imem_req_addr,
        input  id_valid, id_inst, id_pc, id_pc_plus4
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register
// with a one-entry skid buffer, and branch/jump redirect with response drain.
module if_fetch_unit #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              id_valid_q;
    logic [INST_W-1:0] id_inst_q;
    logic [WIDTH-1:0]  id_pc_q;
    logic [WIDTH-1:0]  id_pc_plus4_q;
    logic [INST_W-1:0] skid_inst;
    logic [WIDTH-1:0]  skid_pc;

    logic              id_free;
    logic              load_id;
    logic              load_skid;
    logic              skid_to_id;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  tgt_aligned;

    assign id_free     = !id_valid_q || bus.id_ready;
    assign pc_plus4    = bus.pc_addr + WIDTH'(4);
    assign tgt_aligned = {bus.redirect_target[WIDTH-1:2], 2'b00};

    always_comb begin
        state_nxt          = state;
        bus.pc_load        = 1'b0;
        bus.nxt_pc         = pc_plus4;
        bus.imem_req_valid = 1'b0;
        load_id            = 1'b0;
        load_skid          = 1'b0;
        skid_to_id         = 1'b0;
        if (rst) begin
            state_nxt = REQ;
        end else if (bus.redirect_valid) begin
            bus.pc_load = 1'b1;
            bus.nxt_pc  = tgt_aligned;
            // A response arriving with the redirect retires the outstanding request.
            unique case (state)
                WAIT, DRAIN: state_nxt = bus.imem_rsp_valid ? REQ : DRAIN;
                default:     state_nxt = REQ;
            endcase
        end else begin
            unique case (state)
                REQ: begin
                    bus.imem_req_valid = 1'b1;
                    if (bus.imem_req_ready) state_nxt = WAIT;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        bus.pc_load = 1'b1;
                        if (id_free) begin
                            load_id   = 1'b1;
                            state_nxt = REQ;
                        end else begin
                            load_skid = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.id_ready) begin
                        skid_to_id = 1'b1;
                        state_nxt  = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rsp_valid) state_nxt = REQ;
                end
                default: state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= REQ;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q    <= 1'b0;
            id_inst_q     <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else if (bus.redirect_valid) begin
            id_valid_q <= 1'b0;
        end else if (load_id) begin
            id_valid_q    <= 1'b1;
            id_inst_q     <= bus.imem_rsp_data;
            id_pc_q       <= bus.pc_addr;
            id_pc_plus4_q <= pc_plus4;
        end else if (skid_to_id) begin
            id_valid_q    <= 1'b1;
            id_inst_q     <= skid_inst;
            id_pc_q       <= skid_pc;
            id_pc_plus4_q <= skid_pc + WIDTH'(4);
        end else if (id_valid_q && bus.id_ready) begin
            id_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_inst <= '0;
            skid_pc   <= '0;
        end else if (load_skid) begin
            skid_inst <= bus.imem_rsp_data;
            skid_pc   <= bus.pc_addr;
        end
    end

    assign bus.imem_req_addr = bus.pc_addr;
    assign bus.id_valid      = id_valid_q;
    assign bus.id_inst       = id_inst_q;
    assign bus.id_pc         = id_pc_q;
    assign bus.id_pc_plus4   = id_pc_plus4_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, straight-line fetch, back-pressure,
// redirects, latency and address wrap, with a behavioural program counter.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] pc;
    int vec = 0;
    int errs = 0;

    if_fetch_unit_if #(.WIDTH(32), .INST_W(32)) b ();

    if_fetch_unit #(.WIDTH(32), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    // Program counter register fed by the fetch unit.
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (b.pc_load) pc <= b.nxt_pc;
    end
    assign b.pc_addr = pc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.redirect_valid  = 1'b0;
        b.redirect_target = '0;
        b.imem_req_ready  = 1'b1;
        b.imem_rsp_valid  = 1'b0;
        b.imem_rsp_data   = '0;
        b.id_ready        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            vec++;
            if (b.imem_req_valid !== 1'b0 || b.pc_load !== 1'b0 || b.id_valid !== 1'b0) begin
                errs++;
                $display("FAIL reset_hold: req_valid=%b pc_load=%b id_valid=%b want 0/0/0",
                         b.imem_req_valid, b.pc_load, b.id_valid);
            end
        end
        step();
        rst = 1'b0;
        #1;
        vec++;
        if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h0 || b.id_inst !== 32'h0
            || b.id_pc !== 32'h0 || b.id_pc_plus4 !== 32'h0) begin
            errs++;
            $display("FAIL reset_release: req_valid=%b addr=%h id_inst=%h want 1 0 0",
                     b.imem_req_valid, b.imem_req_addr, b.id_inst);
        end
    endtask

    task automatic test_straight();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            vec++;
            if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== a) begin
                errs++;
                $display("FAIL straight_req%0d: valid=%b addr=%h want 1 %h",
                         i, b.imem_req_valid, b.imem_req_addr, a);
            end
            step();
            b.imem_rsp_valid = 1'b1;
            b.imem_rsp_data  = 32'h1000 + 32'(i);
            #1;
            vec++;
            if (b.pc_load !== 1'b1 || b.nxt_pc !== a + 32'h4) begin
                errs++;
                $display("FAIL straight_pcload%0d: pc_load=%b nxt_pc=%h want 1 %h",
                         i, b.pc_load, b.nxt_pc, a + 32'h4);
            end
            step();
            b.imem_rsp_valid = 1'b0;
            #1;
            vec++;
            if (b.id_valid !== 1'b1 || b.id_pc !== a || b.id_pc_plus4 !== a + 32'h4
                || b.id_inst !== 32'h1000 + 32'(i) || b.pc_load !== 1'b0) begin
                errs++;
                $display("FAIL straight_id%0d: v=%b pc=%h p4=%h inst=%h want 1 %h %h %h",
                         i, b.id_valid, b.id_pc, b.id_pc_plus4, b.id_inst,
                         a, a + 32'h4, 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        b.redirect_valid  = 1'b1;
        b.redirect_target = 32'h0;
        #1;
        vec++;
        if (b.imem_req_valid !== 1'b0 || b.pc_load !== 1'b1 || b.nxt_pc !== 32'h0) begin
            errs++;
            $display("FAIL bp_redirect: req_valid=%b pc_load=%b nxt=%h want 0 1 0",
                     b.imem_req_valid, b.pc_load, b.nxt_pc);
        end
        step();
        b.redirect_valid = 1'b0;
        step();
        b.imem_rsp_valid = 1'b1;
        b.imem_rsp_data  = 32'h00000013;
        step();
        b.imem_rsp_valid = 1'b0;
        b.id_ready       = 1'b0;
        #1;
        vec++;
        if (b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h4 || b.id_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_req4: valid=%b addr=%h id_valid=%b want 1 4 1",
                     b.imem_req_valid, b.imem_req_addr, b.id_valid);
        end
        step();
        b.imem_rsp_valid = 1'b1;
        b.imem_rsp_data  = 32'h2402000A;
        #1;
        vec++;
        if (b.pc_load !== 1'b1 || b.nxt_pc !== 32'h8) begin
            errs++;
            $display("FAIL bp_pcload: pc_load=%b nxt=%h want 1 8", b.pc_load, b.nxt_pc);
        end
        step();
        b.imem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++;
            if (b.imem_req_valid !== 1'b0 || b.pc_load !== 1'b0 || b.id_valid !== 1'b1
                || b.id_pc !== 32'h0 || b.id_inst !== 32'h00000013) begin
                errs++;
                $display("FAIL bp_hold%0d: req=%b ld=%b v=%b pc=%h inst=%h want 0 0 1 0 13",
                         i, b.imem_req_valid, b.pc_load, b.id_valid, b.id_pc, b.id_inst);
            end
            step();
        end
        b.id_ready = 1'b1;
        step();
        #1;
        vec++;
        if (b.id_valid !== 1'b1 || b.id_inst !== 32'h2402000A || b.id_pc !== 32'h4
            || b.id_pc_plus4 !== 32'h8 || b.imem_req_valid !== 1'b1
            || b.imem_req_addr !== 32'h8) begin
            errs++;
            $display("FAIL bp_release: v=%b inst=%h pc=%h p4=%h req=%b addr=%h want 1 2402000a 4 8 1 8",
                     b.id_valid, b.id_inst, b.id_pc, b.id_pc_plus4,
                     b.imem_req_valid, b.imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        step();
        b.redirect_valid  = 1'b1;
        b.redirect_target = 32'h103;
        #1;
        vec++;
        if (b.pc_load !== 1'b1 || b.nxt_pc !== 32'h100) begin
            errs++;
            $display("FAIL rw_pcload: pc_load=%b nxt=%h want 1 100", b.pc_load, b.nxt_pc);
        end
        step();
        b.redirect_valid = 1'b0;
        #1;
        vec++;
        if (b.imem_req_valid !== 1'b0 || b.id_valid !== 1'b0) begin
            errs++;
            $display("FAIL rw_drain: req=%b id_valid=%b want 0 0", b.imem_req_valid, b.id_valid);
        end
        b.imem_rsp_valid = 1'b1;
        b.imem_rsp_data  = 32'hDEADBEEF;
        #1;
        vec++;
        if (b.pc_load !== 1'b0) begin
            errs++;
            $display("FAIL rw_drop_pcload: pc_load=%b want 0", b.pc_load);
        end
        step();
        b.imem_rsp_valid = 1'b0;
        #1;
        vec++;
        if (b.id_valid !== 1'b0 || b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h100) begin
            errs++;
            $display("FAIL rw_next: id_valid=%b req=%b addr=%h want 0 1 100",
                     b.id_valid, b.imem_req_valid, b.imem_req_addr);
        end
    endtask

    task automatic test_redirect_rsp();
        step();
        b.imem_rsp_valid  = 1'b1;
        b.imem_rsp_data   = 32'h12345678;
        b.redirect_valid  = 1'b1;
        b.redirect_target = 32'h200;
        #1;
        vec++;
        if (b.pc_load !== 1'b1 || b.nxt_pc !== 32'h200) begin
            errs++;
            $display("FAIL rr_pcload: pc_load=%b nxt=%h want 1 200", b.pc_load, b.nxt_pc);
        end
        step();
        b.imem_rsp_valid = 1'b0;
        b.redirect_valid = 1'b0;
        #1;
        vec++;
        if (b.id_valid !== 1'b0 || b.imem_req_valid !== 1'b1 || b.imem_req_addr !== 32'h200) begin
            errs++;
            $display("FAIL rr_next: id_valid=%b req=%b addr=%h want 0 1 200",
                     b.id_valid, b.imem_req_valid, b.imem_req_addr);
        end
    endtask

    task automatic test_latency();
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++;
            if (b.imem_req_valid !== 1'b0 || b.pc_load !== 1'b0 || b.id_valid !== 1'b0) begin
                errs++;
                $display("FAIL lat_wait%0d: req=%b ld=%b v=%b want 0 0 0",
                         i, b.imem_req_valid, b.pc_load, b.id_valid);
            end
            step();
        end
        b.imem_rsp_valid = 1'b1;
        b.imem_rsp_data  = 32'hCAFE0001;
        step();
        b.imem_rsp_valid = 1'b0;
        #1;
        vec++;
        if (b.id_valid !== 1'b1 || b.id_pc !== 32'h200 || b.id_inst !== 32'hCAFE0001
            || b.imem_req_addr !== 32'h204 || b.imem_req_valid !== 1'b1) begin
            errs++;
            $display("FAIL lat_done: v=%b pc=%h inst=%h req=%b addr=%h want 1 200 cafe0001 1 204",
                     b.id_valid, b.id_pc, b.id_inst, b.imem_req_valid, b.imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        b.redirect_valid  = 1'b1;
        b.redirect_target = 32'hFFFFFFFF;
        #1;
        vec++;
        if (b.nxt_pc !== 32'hFFFFFFFC) begin
            errs++;
            $display("FAIL wrap_align: nxt=%h want fffffffc", b.nxt_pc);
        end
        step();
        b.redirect_valid = 1'b0;
        #1;
        vec++;
        if (b.imem_req_addr !== 32'hFFFFFFFC || b.imem_req_valid !== 1'b1) begin
            errs++;
            $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc",
                     b.imem_req_valid, b.imem_req_addr);
        end
        step();
        b.imem_rsp_valid = 1'b1;
        b.imem_rsp_data  = 32'h00000055;
        #1;
        vec++;
        if (b.pc_load !== 1'b1 || b.nxt_pc !== 32'h0) begin
            errs++;
            $display("FAIL wrap_nxt: pc_load=%b nxt=%h want 1 0", b.pc_load, b.nxt_pc);
        end
        step();
        b.imem_rsp_valid = 1'b0;
        #1;
        vec++;
        if (b.id_pc !== 32'hFFFFFFFC || b.id_pc_plus4 !== 32'h0 || b.imem_req_addr !== 32'h0) begin
            errs++;
            $display("FAIL wrap_id: pc=%h p4=%h addr=%h want fffffffc 0 0",
                     b.id_pc, b.id_pc_plus4, b.imem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_latency();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
